// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo_param FIFO: width math and pointer wrap.
package sync_fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] fifo_ptr_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        longint unsigned pow;
        res = 0;
        pow = 1;
        while (pow < longint'(value)) begin
            pow = pow << 1;
            res++;
        end
        return res;
    endfunction

    // Occupancy counter width: must hold 0..DEPTH inclusive.
    function automatic int unsigned calc_cw(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    // Pointer width, never below one bit.
    function automatic int unsigned calc_aw(input int unsigned depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Explicit wrap after DEPTH-1 so non-power-of-two depths work.
    function automatic fifo_ptr_t next_ptr(input fifo_ptr_t ptr, input int unsigned depth);
        return (ptr == fifo_ptr_t'(depth - 1)) ? '0 : ptr + fifo_ptr_t'(1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage for sync_fifo_param: DATA_W x DEPTH register array, one write
// port and a registered read port that holds its value when not reading.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = calc_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-slot write in the same cycle is seen next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock circular-buffer FIFO with occupancy count and
// almost-full/almost-empty flags. Optional sticky error flags are built when
// SYNC_FIFO_ERR_STICKY_EN is defined (adds err_clr, overflow_err, underflow_err).
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned DATA_W   = 8,
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned AF_LEVEL = DEPTH - 1,
    parameter  int unsigned AE_LEVEL = 1,
    localparam int unsigned CW       = calc_cw(DEPTH),
    localparam int unsigned AW       = calc_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_req,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_req,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              full_sig,
    output logic              empty_sig,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count
`ifdef SYNC_FIFO_ERR_STICKY_EN
    ,
    input  logic              err_clr,
    output logic              overflow_err,
    output logic              underflow_err
`endif
);

    typedef logic [AW-1:0] ptr_t;

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic wr_acc;
    logic rd_acc;

    // Flags come from the count register only; accepts combine them with requests.
    always_comb begin
        full_sig     = (count == CW'(DEPTH));
        empty_sig    = (count == '0);
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
        wr_acc       = write_req && (!full_sig || read_req);
        rd_acc       = read_req && !empty_sig;
    end

    // Pointers, occupancy and read_valid; simultaneous accept leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= AW'(next_ptr(fifo_ptr_t'(wr_ptr), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= AW'(next_ptr(fifo_ptr_t'(rd_ptr), DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (write_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (read_data)
    );

`ifdef SYNC_FIFO_ERR_STICKY_EN
    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (write_req && full_sig && !read_req) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
            if (read_req && empty_sig) begin
                underflow_err <= 1'b1;
            end else if (err_clr) begin
                underflow_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: instance A (DATA_W=8, DEPTH=4)
// for directed boundary cases, instance B (DATA_W=16, DEPTH=5) for random
// interleaved traffic across pointer wrap. A queue scoreboard per instance.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A signals
    logic        a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0]  a_wd = '0;
    logic [7:0]  a_read_data;
    logic        a_rv, a_full, a_empty, a_af, a_ae;
    logic [2:0]  a_count;
    // Instance B signals
    logic        b_wr = 1'b0, b_rd = 1'b0;
    logic [15:0] b_wd = '0;
    logic [15:0] b_read_data;
    logic        b_rv, b_full, b_empty, b_af, b_ae;
    logic [2:0]  b_count;
`ifdef SYNC_FIFO_ERR_STICKY_EN
    logic a_clr = 1'b0, b_clr = 1'b0;
    logic a_ovf, a_unf, b_ovf, b_unf;
`endif

    sync_fifo_param #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_req    (a_wr),
        .write_data   (a_wd),
        .read_req     (a_rd),
        .read_data    (a_read_data),
        .read_valid   (a_rv),
        .full_sig     (a_full),
        .empty_sig    (a_empty),
        .almost_full  (a_af),
        .almost_empty (a_ae),
        .count        (a_count)
`ifdef SYNC_FIFO_ERR_STICKY_EN
        ,
        .err_clr       (a_clr),
        .overflow_err  (a_ovf),
        .underflow_err (a_unf)
`endif
    );

    sync_fifo_param #(
        .DATA_W (16),
        .DEPTH  (5)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_req    (b_wr),
        .write_data   (b_wd),
        .read_req     (b_rd),
        .read_data    (b_read_data),
        .read_valid   (b_rv),
        .full_sig     (b_full),
        .empty_sig    (b_empty),
        .almost_full  (b_af),
        .almost_empty (b_ae),
        .count        (b_count)
`ifdef SYNC_FIFO_ERR_STICKY_EN
        ,
        .err_clr       (b_clr),
        .overflow_err  (b_ovf),
        .underflow_err (b_unf)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model state, index 0 = A, 1 = B
    int          m_cnt   [2];
    logic [15:0] m_rdata [2];
    bit          m_ovf   [2];
    bit          m_unf   [2];
    bit          clr     [2];
    logic [15:0] sb_a [$];
    logic [15:0] sb_b [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int unsigned i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_rdata[i] = '0;
            m_ovf[i]   = 1'b0;
            m_unf[i]   = 1'b0;
        end
        sb_a.delete();
        sb_b.delete();
    endtask

    task automatic check_outputs(input int sel, input bit exp_rv);
        int          depth;
        string       p;
        logic [15:0] rdata;
        logic [2:0]  cnt;
        logic        rv, full, empty, af, ae;
        depth = (sel != 0) ? 5 : 4;
        p     = (sel != 0) ? "B." : "A.";
        rdata = (sel != 0) ? b_read_data : {8'h00, a_read_data};
        cnt   = (sel != 0) ? b_count : a_count;
        rv    = (sel != 0) ? b_rv : a_rv;
        full  = (sel != 0) ? b_full : a_full;
        empty = (sel != 0) ? b_empty : a_empty;
        af    = (sel != 0) ? b_af : a_af;
        ae    = (sel != 0) ? b_ae : a_ae;
        check({p, "read_valid"}, 32'(rv), 32'(exp_rv));
        check({p, "read_data"}, 32'(rdata), 32'(m_rdata[sel]));
        check({p, "count"}, 32'(cnt), 32'(m_cnt[sel]));
        check({p, "full"}, 32'(full), 32'(m_cnt[sel] == depth));
        check({p, "empty"}, 32'(empty), 32'(m_cnt[sel] == 0));
        check({p, "almost_full"}, 32'(af), 32'(m_cnt[sel] >= depth - 1));
        check({p, "almost_empty"}, 32'(ae), 32'(m_cnt[sel] <= 1));
`ifdef SYNC_FIFO_ERR_STICKY_EN
        check({p, "overflow_err"}, 32'((sel != 0) ? b_ovf : a_ovf), 32'(m_ovf[sel]));
        check({p, "underflow_err"}, 32'((sel != 0) ? b_unf : a_unf), 32'(m_unf[sel]));
`endif
    endtask

    // One clock of stimulus on one instance, with model update and output check.
    task automatic step(input int sel, input bit wr, input logic [15:0] d, input bit rd);
        int          depth;
        bit          wa, ra;
        logic [15:0] dm;
        depth = (sel != 0) ? 5 : 4;
        dm    = (sel != 0) ? d : {8'h00, d[7:0]};
        wa    = wr && (m_cnt[sel] != depth || rd);
        ra    = rd && (m_cnt[sel] != 0);
        if (sel != 0) begin
            b_wr = wr; b_wd = d; b_rd = rd;
        end else begin
            a_wr = wr; a_wd = d[7:0]; a_rd = rd;
        end
`ifdef SYNC_FIFO_ERR_STICKY_EN
        a_clr = clr[0];
        b_clr = clr[1];
`endif
        if (wr && m_cnt[sel] == depth && !rd) m_ovf[sel] = 1'b1;
        else if (clr[sel]) m_ovf[sel] = 1'b0;
        if (rd && m_cnt[sel] == 0) m_unf[sel] = 1'b1;
        else if (clr[sel]) m_unf[sel] = 1'b0;
        if (ra) begin
            m_rdata[sel] = (sel != 0) ? sb_b.pop_front() : sb_a.pop_front();
        end
        if (wa) begin
            if (sel != 0) sb_b.push_back(dm);
            else sb_a.push_back(dm);
        end
        if (wa && !ra) m_cnt[sel]++;
        if (ra && !wa) m_cnt[sel]--;
        @(posedge clk);
        #1;
        a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
`ifdef SYNC_FIFO_ERR_STICKY_EN
        a_clr = 1'b0;
        b_clr = 1'b0;
`endif
        check_outputs(sel, ra);
    endtask

    initial begin : stimulus
        int unsigned pushed;
        int unsigned iters;
        bit          w, r;
        logic [15:0] val;
        clr[0] = 1'b0;
        clr[1] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0, 1'b0);
        check_outputs(1, 1'b0);
        rst_n = 1'b1;
        step(0, 0, 16'h0, 0);

        // Fill to full, drop a fifth write, drain in order
        step(0, 1, 16'h11, 0);
        step(0, 1, 16'h22, 0);
        step(0, 1, 16'h33, 0);
        step(0, 1, 16'h44, 0);
        step(0, 1, 16'h55, 0);
        for (int unsigned i = 0; i < 4; i++) step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 1);

        // Full with both requests, then drain
        step(0, 1, 16'h11, 0);
        step(0, 1, 16'h22, 0);
        step(0, 1, 16'h33, 0);
        step(0, 1, 16'h44, 0);
        step(0, 1, 16'h66, 1);
        for (int unsigned i = 0; i < 4; i++) step(0, 0, 16'h0, 1);

        // Empty with both requests: write only
        step(0, 1, 16'h77, 1);
        step(0, 0, 16'h0, 1);

        // Random interleave on DEPTH=5 across several pointer wraps
        pushed = 0;
        iters  = 0;
        while ((pushed < 20 || m_cnt[1] != 0) && iters < 400) begin
            w   = (pushed < 20) && ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 1) != 0);
            val = 16'($urandom);
            if (w && (m_cnt[1] != 5 || r)) pushed++;
            step(1, w, val, r);
            iters++;
        end
        check("B.pushed", 32'(pushed), 32'd20);
        check("B.drained", 32'(sb_b.size()), 32'd0);

        // Asynchronous reset mid-stream with count=3
        step(0, 1, 16'hA1, 0);
        step(0, 1, 16'hA2, 0);
        step(0, 1, 16'hA3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(0, 1'b0);
        check_outputs(1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 16'hAB, 0);
        step(0, 0, 16'h0, 1);

`ifdef SYNC_FIFO_ERR_STICKY_EN
        // Underflow sets, clear drops it
        step(0, 0, 16'h0, 1);
        clr[0] = 1'b1;
        step(0, 0, 16'h0, 0);
        clr[0] = 1'b0;
        // Overflow sets; set wins over a same-cycle clear
        for (int unsigned i = 0; i < 4; i++) step(0, 1, 16'(8'hC0 + i), 0);
        step(0, 1, 16'hCF, 0);
        clr[0] = 1'b1;
        step(0, 1, 16'hCE, 0);
        step(0, 0, 16'h0, 0);
        clr[0] = 1'b0;
        step(1, 0, 16'h0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, next generation of the team's small shift-register FIFO. Circular buffer with read/write pointers replaces shifting, so any width and depth cost the same per access. Adds occupancy count, programmable almost-full/almost-empty flags, and defined simultaneous read/write at the full and empty boundaries. Sits between producer/consumer blocks in the same clock domain, such as a UART byte buffer or a sample stream.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2; need not be a power of two)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
write_req  in  1  write request, sampled on clk rise
write_data  in  DATA_W  data to store
read_req  in  1  read request, sampled on clk rise
read_data  out  DATA_W  registered read result
read_valid  out  1  pulses one cycle when read_data updated by an accepted read
full_sig  out  1  count == DEPTH
empty_sig  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CW  occupancy, CW = clog2(DEPTH+1)

Behaviour:
- Reset, asynchronous active-low: wr_ptr=0, rd_ptr=0, count=0, read_data=0, read_valid=0. Flags follow from count: empty_sig=1, almost_empty=1, full_sig=0, almost_full=0 (almost_full=0 because AF_LEVEL>=1). Storage array is not reset.
- Flags and count come combinationally from the count register only. They never depend on the current-cycle requests.
- Accept rules, evaluated on each clk rise:
  - wr_acc = write_req && (!full_sig || read_req)
  - rd_acc = read_req && !empty_sig
- Full with both requests: both are accepted. The write lands in the slot the read frees. count is unchanged.
- Empty with both requests: only the write is accepted, with no bypass. count goes 0->1. read_data holds. read_valid=0.
- Write when full without a read: dropped. No state change.
- Read when empty: ignored. read_data holds. read_valid=0.
- Read latency: on a clk rise with rd_acc, read_data <= mem[rd_ptr]. read_valid=1 for that following cycle. Without rd_acc, read_data holds and read_valid=0.
- Write: on wr_acc, mem[wr_ptr] <= write_data.
- Pointers: AW = max(1, clog2(DEPTH)). Each pointer increments on its accept. It wraps to 0 explicitly after DEPTH-1, which allows non-power-of-two depths.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. It never leaves 0..DEPTH.
- Ordering: strict FIFO. Data read equals data written, in the same order.
- Reset asserted mid-operation: all contents are discarded immediately. First read after reset release returns the first word written after release.

Optional Feature:
Macro SYNC_FIFO_ERR_STICKY_EN.
- Defined:
  - Adds outputs overflow_err and underflow_err, both reset to 0.
  - overflow_err sets on write_req && full_sig && !read_req.
  - underflow_err sets on read_req && empty_sig.
  - Both are sticky until rst_n or a one-cycle input err_clr.
  - If set and clear occur in the same cycle, set wins.
- Not defined: ports overflow_err, underflow_err and err_clr are absent. Dropped requests are silent. All other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg:
  - constant function clog2
  - localparam helpers for CW/AW
  - typedef fifo_ptr_t
- One sub-module, sync_fifo_ram:
  - DATA_W x DEPTH register array, one write port, registered read port
  - inputs: wr_en, wr_addr, wr_data, rd_en, rd_addr
  - output: rd_data
  - Holds rd_data when rd_en=0; no reset on storage.
- Top level holds pointers, count, flags, read_valid and the optional error logic.

Test Plan:
- Reset then idle -> empty_sig=1, almost_empty=1, full_sig=0, count=0, read_data=0, read_valid=0.
- DEPTH=4: write 0x11,0x22,0x33,0x44 -> count=4, full_sig=1, almost_full=1 from count 3. A 5th write of 0x55 is dropped. Read four times -> 0x11,0x22,0x33,0x44 with one-cycle latency, then empty_sig=1.
- Full FIFO, write_req=read_req=1 with data 0x66 -> read_data=0x11, count stays 4. Drain order continues 0x22,0x33,0x44,0x66.
- Empty FIFO, write_req=read_req=1 with 0x77 -> read_valid=0, count=1. Next read returns 0x77.
- DEPTH=5, DATA_W=16: push and pop 20 words in random interleave, crossing pointer wrap several times -> scoreboard match, count never outside 0..5.
- rst_n pulsed low mid-stream with count=3 -> count=0 asynchronously, with flags per reset. Post-reset write 0xAB then read returns 0xAB. With SYNC_FIFO_ERR_STICKY_EN: read when empty sets underflow_err, and err_clr clears it.
